// File: rtl/mod_memstage.sv
`timescale 1ns/1ps
// MEM pipeline stage: performs the data-memory access for loads, stores, PUSH/POP, CALL and RETQ
// over a req/resp port and presents the registered EX_WB packet to writeback.
module mod_memstage #(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_pc,
    input  logic [63:0]   in_alu_result,
    input  logic [63:0]   in_alu_ext_result,
    input  logic [63:0]   in_mem_addr,
    input  logic [63:0]   in_store_data,
    input  logic [7:0]    in_opcode,
    input  logic [3:0]    in_regByte,
    input  logic [3:0]    in_rmByte,
    input  logic          in_sim_end,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_we,
    output logic [63:0]   mem_req_addr,
    output logic [63:0]   mem_req_wdata,
    input  logic          mem_resp_valid,
    input  logic [63:0]   mem_resp_rdata,
    output logic          can_writeback,
    output logic [208:0]  exwb,
    output logic          store_memstage_active,
    output logic          mem_err
);

    localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (RESP_TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic [1:0] {K_NONE, K_WRITE, K_READ} kind_t;

    state_t         state_q;
    kind_t          kind;
    logic [CW-1:0]  cnt_q;
    logic           canWb_q;
    logic           storeActive_q;
    logic           memErr_q;
    logic           reqValid_q;
    logic           reqWe_q;
    logic [63:0]    reqAddr_q;
    logic [63:0]    reqWdata_q;
    logic [63:0]    pc_q;
    logic [63:0]    alu_q;
    logic [63:0]    ext_q;
    logic [7:0]     opcode_q;
    logic [3:0]     regByte_q;
    logic [3:0]     rmByte_q;
    logic           simEnd_q;

    // PUSH (80..87), CALL (232) and the store opcodes write; POP (88..95), RETQ (195) and loads read
    always_comb begin
        kind = K_NONE;
        if (in_opcode == 8'd137 || in_opcode == 8'd232 || in_opcode == 8'd255 ||
            (in_opcode >= 8'd80 && in_opcode <= 8'd87)) begin
            kind = K_WRITE;
        end else if (in_opcode == 8'd139 || in_opcode == 8'd195 ||
                     (in_opcode >= 8'd88 && in_opcode <= 8'd95)) begin
            kind = K_READ;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            canWb_q       <= 1'b0;
            storeActive_q <= 1'b0;
            memErr_q      <= 1'b0;
            reqValid_q    <= 1'b0;
            reqWe_q       <= 1'b0;
            reqAddr_q     <= '0;
            reqWdata_q    <= '0;
            pc_q          <= '0;
            alu_q         <= '0;
            ext_q         <= '0;
            opcode_q      <= '0;
            regByte_q     <= '0;
            rmByte_q      <= '0;
            simEnd_q      <= 1'b0;
        end else begin
            canWb_q       <= 1'b0;
            storeActive_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pc_q       <= in_pc;
                        alu_q      <= in_alu_result;
                        ext_q      <= in_alu_ext_result;
                        opcode_q   <= in_opcode;
                        regByte_q  <= in_regByte;
                        rmByte_q   <= in_rmByte;
                        simEnd_q   <= in_sim_end;
                        reqAddr_q  <= in_mem_addr;
                        reqWdata_q <= in_store_data;
                        if (kind == K_NONE) begin
                            canWb_q <= 1'b1;
                        end else begin
                            state_q    <= REQ;
                            reqValid_q <= 1'b1;
                            reqWe_q    <= (kind == K_WRITE);
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        reqValid_q <= 1'b0;
                        if (reqWe_q) begin
                            state_q       <= IDLE;
                            canWb_q       <= 1'b1;
                            storeActive_q <= 1'b1;
                        end else begin
                            state_q <= RESP;
                            cnt_q   <= '0;
                        end
                    end
                end
                RESP: begin
                    // A response arriving on the limit cycle takes priority over the timeout
                    if (mem_resp_valid) begin
                        alu_q   <= mem_resp_rdata;
                        canWb_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                        alu_q    <= '1;
                        memErr_q <= 1'b1;
                        canWb_q  <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready              = (state_q == IDLE);
    assign mem_req_valid         = reqValid_q;
    assign mem_req_we            = reqWe_q;
    assign mem_req_addr          = reqAddr_q;
    assign mem_req_wdata         = reqWdata_q;
    assign can_writeback         = canWb_q;
    assign store_memstage_active = storeActive_q;
    assign mem_err               = memErr_q;
    assign exwb = {pc_q, alu_q, ext_q, opcode_q, regByte_q, rmByte_q, simEnd_q};

endmodule

// File: tb/tb_mod_memstage.sv
`timescale 1ns/1ps
// Directed bench for mod_memstage: stimulus pushes expected writeback packets into a queue,
// an independent monitor pops and compares them whenever can_writeback pulses.
module tb_mod_memstage;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_pc, in_alu_result, in_alu_ext_result, in_mem_addr, in_store_data;
    logic [7:0]    in_opcode;
    logic [3:0]    in_regByte, in_rmByte;
    logic          in_sim_end;
    logic          mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0]   mem_req_addr, mem_req_wdata;
    logic          mem_resp_valid;
    logic [63:0]   mem_resp_rdata;
    logic          can_writeback;
    logic [208:0]  exwb;
    logic          store_memstage_active;
    logic          mem_err;

    typedef struct packed {
        logic [208:0] exwb;
        logic         store;
    } exp_t;

    exp_t expQ[$];
    int   nApplied = 0;
    int   nMiscompares = 0;

    mod_memstage #(.RESP_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_alu_result(in_alu_result), .in_alu_ext_result(in_alu_ext_result),
        .in_mem_addr(in_mem_addr), .in_store_data(in_store_data),
        .in_opcode(in_opcode), .in_regByte(in_regByte), .in_rmByte(in_rmByte), .in_sim_end(in_sim_end),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .can_writeback(can_writeback), .exwb(exwb),
        .store_memstage_active(store_memstage_active), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the packet was accepted
    task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] ext,
                                 input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] op,
                                 input logic [3:0] rb, input logic [3:0] rm, input logic se,
                                 input logic [63:0] expAlu, input logic expStore, input logic expectWb);
        in_pc = pc; in_alu_result = alu; in_alu_ext_result = ext;
        in_mem_addr = addr; in_store_data = wdata; in_opcode = op;
        in_regByte = rb; in_rmByte = rm; in_sim_end = se;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            in_valid = 1'b0;
            checkOutput("accept_timeout", {63'b0, in_ready}, 64'd1);
            return;
        end
        if (expectWb) expQ.push_back('{exwb: {pc, expAlu, ext, op, rb, rm, se}, store: expStore});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (can_writeback) begin
                nApplied++;
                if (expQ.size() == 0) begin
                    nMiscompares++;
                    $display("[TB] FAIL unexpected_writeback: got can_writeback=1, expected no packet");
                end else begin
                    e = expQ.pop_front();
                    if (exwb !== e.exwb || store_memstage_active !== e.store) begin
                        nMiscompares++;
                        $display("[TB] FAIL wb_packet: got exwb=%h store=%b, expected exwb=%h store=%b",
                                 exwb, store_memstage_active, e.exwb, e.store);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d vectors applied", nApplied);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        reset_n = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_alu_result = '0; in_alu_ext_result = '0; in_mem_addr = '0; in_store_data = '0;
        in_opcode = '0; in_regByte = '0; in_rmByte = '0; in_sim_end = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_can_wb", {63'b0, can_writeback}, 64'd0);
        checkOutput("reset_req_valid", {63'b0, mem_req_valid}, 64'd0);
        checkOutput("reset_mem_err", {63'b0, mem_err}, 64'd0);
        checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("reset_exwb_alu", exwb[144:81], 64'd0);
        checkOutput("reset_req_addr", mem_req_addr, 64'd0);
        reset_n = 1'b1;

        // Stale response while idle must never reach writeback
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234;
        repeat (2) @(negedge clk);
        mem_resp_valid = 1'b0;

        applyStimulus(64'h100, 64'd5, 64'h0, 64'h0, 64'h0, 8'h01, 4'd2, 4'd3, 1'b0, 64'd5, 1'b0, 1'b1);
        checkOutput("none_latency", {63'b0, can_writeback}, 64'd1);
        @(negedge clk);
        checkOutput("none_pulse_width", {63'b0, can_writeback}, 64'd0);

        // Back-to-back pass-through ops, including 247 and a sim_end packet
        applyStimulus(64'h110, 64'h11, 64'h1, 64'h0, 64'h0, 8'd247, 4'd1, 4'd1, 1'b0, 64'h11, 1'b0, 1'b1);
        checkOutput("b2b_0", {63'b0, can_writeback}, 64'd1);
        applyStimulus(64'h118, 64'h22, 64'h2, 64'h0, 64'h0, 8'h20, 4'd2, 4'd2, 1'b1, 64'h22, 1'b0, 1'b1);
        checkOutput("b2b_1", {63'b0, can_writeback}, 64'd1);
        applyStimulus(64'h120, 64'h33, 64'h3, 64'h0, 64'h0, 8'h30, 4'd3, 4'd3, 1'b0, 64'h33, 1'b0, 1'b1);
        checkOutput("b2b_2", {63'b0, can_writeback}, 64'd1);

        // Load with delayed ready and response two cycles into RESP
        applyStimulus(64'h200, 64'h1000, 64'h0, 64'h1000, 64'h0, 8'd139, 4'd1, 4'd0, 1'b0, 64'hDEAD, 1'b0, 1'b1);
        checkOutput("load_req_valid", {63'b0, mem_req_valid}, 64'd1);
        checkOutput("load_req_we", {63'b0, mem_req_we}, 64'd0);
        checkOutput("load_in_ready", {63'b0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("load_hold_valid", {63'b0, mem_req_valid}, 64'd1);
            checkOutput("load_hold_addr", mem_req_addr, 64'h1000);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checkOutput("load_req_drop", {63'b0, mem_req_valid}, 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEAD;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checkOutput("load_wb", {63'b0, can_writeback}, 64'd1);
        checkOutput("load_in_ready_back", {63'b0, in_ready}, 64'd1);

        // PUSH with immediate ready
        mem_req_ready = 1'b1;
        applyStimulus(64'h300, 64'h7FF8, 64'h0, 64'h7FF8, 64'h42, 8'h50, 4'd4, 4'd4, 1'b0, 64'h7FF8, 1'b1, 1'b1);
        checkOutput("push_we", {63'b0, mem_req_we}, 64'd1);
        checkOutput("push_addr", mem_req_addr, 64'h7FF8);
        checkOutput("push_wdata", mem_req_wdata, 64'h42);
        checkOutput("push_wb_early", {63'b0, can_writeback}, 64'd0);
        @(negedge clk);
        mem_req_ready = 1'b0;
        checkOutput("push_wb", {63'b0, can_writeback}, 64'd1);
        checkOutput("push_store_flag", {63'b0, store_memstage_active}, 64'd1);
        checkOutput("push_req_drop", {63'b0, mem_req_valid}, 64'd0);

        // RETQ whose response lands on the fourth RESP cycle: response wins
        mem_req_ready = 1'b1;
        applyStimulus(64'h400, 64'h7000, 64'h0, 64'h7000, 64'h0, 8'd195, 4'd0, 4'd4, 1'b0, 64'h4444, 1'b0, 1'b1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h4444;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checkOutput("limit_wb", {63'b0, can_writeback}, 64'd1);
        checkOutput("limit_no_err", {63'b0, mem_err}, 64'd0);

        // RETQ with no response times out after four RESP cycles
        mem_req_ready = 1'b1;
        applyStimulus(64'h500, 64'h7008, 64'h0, 64'h7008, 64'h0, 8'd195, 4'd0, 4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        checkOutput("timeout_busy", {63'b0, in_ready}, 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("timeout_err_early", {63'b0, mem_err}, 64'd0);
        checkOutput("timeout_busy_late", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        checkOutput("timeout_err", {63'b0, mem_err}, 64'd1);
        checkOutput("timeout_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("timeout_wb", {63'b0, can_writeback}, 64'd1);
        @(negedge clk);
        checkOutput("timeout_err_sticky", {63'b0, mem_err}, 64'd1);

        // Reset while a load waits in REQ, then a late response
        applyStimulus(64'h600, 64'h2000, 64'h0, 64'h2000, 64'h0, 8'd139, 4'd1, 4'd0, 1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("rst_req_valid_before", {63'b0, mem_req_valid}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_req_drop", {63'b0, mem_req_valid}, 64'd0);
        checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("rst_err_clear", {63'b0, mem_err}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hBAD;
        repeat (2) @(negedge clk);
        mem_resp_valid = 1'b0;
        checkOutput("rst_no_wb", {63'b0, can_writeback}, 64'd0);

        applyStimulus(64'h700, 64'h77, 64'h7, 64'h0, 64'h0, 8'h05, 4'd7, 4'd7, 1'b0, 64'h77, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end

endmodule
